// File: rtl/tile_streamer_pkg.sv
// Shared types and sizing for the tile transpose path (tile mover / tile streamer).
// Holds the FSM state enum, channel-slice constant and the ct/total helpers.
package tile_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    COMPLETE
  } state_t;

  localparam int CS          = 4;
  localparam int DIM_WIDTH   = 8;
  localparam int CT_WIDTH    = DIM_WIDTH - $clog2(CS);
  localparam int TOTAL_WIDTH = 16;

  // Channel tiles per row; channels beyond the last full group of CS are dropped.
  function automatic logic [CT_WIDTH-1:0] calc_ct(input logic [DIM_WIDTH-1:0] c_dim);
    return CT_WIDTH'(c_dim >> $clog2(CS));
  endfunction

  function automatic logic [TOTAL_WIDTH-1:0] calc_total(input logic [DIM_WIDTH-1:0] b_dim,
                                                        input logic [DIM_WIDTH-1:0] w_dim,
                                                        input logic [CT_WIDTH-1:0]  ct);
    return TOTAL_WIDTH'(32'(b_dim) * 32'(w_dim) * 32'(ct));
  endfunction

endpackage

// File: rtl/tile_streamer_fifo.sv
// Show-ahead synchronous FIFO: head word is always visible at head while not empty.
// Push and pop may coincide at any occupancy, including full.
module sync_fifo #(
  parameter  int DATA_WIDTH = 64,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is a handful of flops, so it is reset to keep the head (and m_data) at 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
    else $error("sync_fifo: push into full FIFO");

endmodule

// File: rtl/tile_streamer.sv
// Drains a finished (w, b, ct) tile from the buffer read port as a valid/ready stream.
// Optional TILE_STREAMER_ROW_LAST_EN adds m_row_last marking the last ct word of each row.
module tile_streamer
  import tile_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  b_dim,
  input  logic [DIM_WIDTH-1:0]  w_dim,
  input  logic [DIM_WIDTH-1:0]  c_dim,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_csb,
  input  logic [DATA_WIDTH-1:0] rd_dout,
  input  logic                  rd_dout_vld,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef TILE_STREAMER_ROW_LAST_EN
  ,
  output logic                  m_row_last
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic [TOTAL_WIDTH-1:0] issued;
  logic [TOTAL_WIDTH-1:0] pop_cnt;
  logic [CW-1:0]          inflight;
  logic [TOTAL_WIDTH-1:0] start_total;

  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW:0]            credit_used;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   capture;

  assign start_total = calc_total(b_dim, w_dim, calc_ct(c_dim));
  assign capture     = (state == IDLE) && start;

  // Credit counts only registered occupancy; a pop this cycle frees a slot next cycle.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state == STREAM) && (issued < total_q) &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign push        = rd_dout_vld && (state != IDLE);
  assign pop         = m_valid && m_ready;

  assign rd_csb  = !issue;
  assign rd_addr = base_q + ADDR_WIDTH'(issued);
  assign m_valid = !fifo_empty;
  assign m_last  = m_valid && (pop_cnt == total_q - TOTAL_WIDTH'(1));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_dout),
    .pop       (pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every output of this block gets a default first so no path can hold a value and infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = (start_total == '0) ? COMPLETE : STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (issued == total_q) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight == '0 && (fifo_empty || (fifo_count == CW'(1) && pop)))
          state_next = COMPLETE;
      end
      COMPLETE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      total_q  <= '0;
      issued   <= '0;
      pop_cnt  <= '0;
      inflight <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight + CW'(issue) - CW'(push);
      if (capture) begin
        base_q  <= base_addr;
        total_q <= start_total;
        issued  <= '0;
        pop_cnt <= '0;
      end else begin
        if (issue) issued  <= issued + 1'b1;
        if (pop)   pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

`ifdef TILE_STREAMER_ROW_LAST_EN
  // ct position of the FIFO head word; advances with each pop and wraps per row.
  logic [CT_WIDTH-1:0] ct_q;
  logic [CT_WIDTH-1:0] head_ct;

  assign m_row_last = m_valid && (head_ct == ct_q - CT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q    <= '0;
      head_ct <= '0;
    end else if (capture) begin
      ct_q    <= calc_ct(c_dim);
      head_ct <= '0;
    end else if (pop) begin
      head_ct <= (head_ct == ct_q - CT_WIDTH'(1)) ? '0 : head_ct + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_streamer.sv
// Directed self-checking bench for tile_streamer with a variable-latency buffer model.
// Build with TILE_STREAMER_ROW_LAST_EN to also check m_row_last.
`timescale 1ns/1ps
module tb_tile_streamer;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    b_dim = '0, w_dim = '0, c_dim = '0;
  logic          start = 1'b0;
  logic          busy, done, rd_csb, m_valid, m_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dout, m_data;
  logic          rd_dout_vld;
  logic          m_ready = 1'b1;
  logic          row_bit;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tile_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .b_dim(b_dim), .w_dim(w_dim),
    .c_dim(c_dim), .start(start), .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_csb(rd_csb), .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef TILE_STREAMER_ROW_LAST_EN
    , .m_row_last(row_bit)
`endif
  );
`ifndef TILE_STREAMER_ROW_LAST_EN
  assign row_bit = 1'b0;
`endif

  // Buffer contents: every address holds a distinct, recognisable word.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3, a + 8'd1, a, 8'h96, ~a};
  endfunction

  // Buffer read port with in-order latency lat (1..4); not reset, like the real SRAM pipeline.
  int            lat = 1;
  logic          pv [4] = '{default: 1'b0};
  logic [AW-1:0] pa [4] = '{default: '0};
  always @(posedge clk) begin
    pv[0] <= !rd_csb;
    pa[0] <= rd_addr;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign rd_dout_vld = pv[lat-1];
  assign rd_dout     = data_of(pa[lat-1]);

  // Monitor, sampled mid-cycle; k is the cycle index with start sampled at edge 0.
  int            cyc = 0;
  int            t0  = 0;
  logic [AW-1:0] issue_q [$];
  logic [DW-1:0] out_d [$];
  bit            out_l [$];
  bit            out_r [$];
  int            first_csb, last_csb, first_vld, done_cyc, last_hs;
  int            n_issue, n_pop, max_out, credit_err, stable_err;
  bit            any_valid, stall_prev;
  logic [DW-1:0] data_prev;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    int k;
    k = cyc - t0 + 1;
    if (rst_n) begin
      if (!rd_csb) begin
        if (n_issue - n_pop >= DEPTH) credit_err++;
        issue_q.push_back(rd_addr);
        if (first_csb < 0) first_csb = k;
        last_csb = k;
        n_issue++;
      end
      if (n_issue - n_pop > max_out) max_out = n_issue - n_pop;
      if (m_valid) begin
        any_valid = 1'b1;
        if (first_vld < 0) first_vld = k;
      end
      if (stall_prev && (!m_valid || m_data !== data_prev)) stable_err++;
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      if (m_valid && m_ready) begin
        out_d.push_back(m_data);
        out_l.push_back(m_last);
        out_r.push_back(row_bit);
        n_pop++;
        last_hs = k;
      end
      if (done && done_cyc < 0) done_cyc = k;
    end
  end

  task automatic clear_mon();
    issue_q.delete(); out_d.delete(); out_l.delete(); out_r.delete();
    first_csb = -1; last_csb = -1; first_vld = -1; done_cyc = -1; last_hs = -1;
    n_issue = 0; n_pop = 0; max_out = 0; credit_err = 0; stable_err = 0;
    any_valid = 1'b0; stall_prev = 1'b0;
  endtask

  // Mismatches of observed words against the bench's expectation of the tile.
  function automatic int stream_errors(input logic [AW-1:0] base, input int total, input int ct);
    int e = 0;
    for (int i = 0; i < out_d.size(); i++) begin
      if (out_d[i] !== data_of(base + AW'(i))) e++;
      if (out_l[i] !== (i == total - 1)) e++;
`ifdef TILE_STREAMER_ROW_LAST_EN
      if (out_r[i] !== ((i % ct) == ct - 1)) e++;
`endif
    end
    if (ct < 0) e++;
    return e;
  endfunction

  function automatic int issue_errors(input logic [AW-1:0] base, input int total);
    int e = 0;
    if (issue_q.size() != total) e++;
    for (int i = 0; i < issue_q.size(); i++)
      if (issue_q[i] !== base + AW'(i)) e++;
    return e;
  endfunction

  // Called just after a posedge; start is held high until done to show it is ignored mid-tile.
  task automatic run_tile(input logic [AW-1:0] base, input logic [7:0] b, input logic [7:0] w,
                          input logic [7:0] c, input int mode, output bit to);
    clear_mon();
    base_addr = base; b_dim = b; w_dim = w; c_dim = c;
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    to = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      m_ready = (mode == 0) ? 1'b1 : (n % 3 == 2);
      @(posedge clk); #1;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, rd_csb, rd_addr, m_valid, m_last} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/done/csb/addr/valid/last=%b, expected 0_0_1_00000000_0_0",
               {busy, done, rd_csb, rd_addr, m_valid, m_last});
    end
    tests_run++;
    if (m_data !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h, expected 0", m_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit to; int e;
    lat = 1;
    run_tile(8'h10, 8'd2, 8'd3, 8'd8, 0, to);
    tests_run++;
    if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: done not seen"); end
    e = issue_errors(8'h10, 12);
    tests_run++;
    if (e !== 0) begin tests_failed++; $display("FAIL basic_addr: %0d bad reads of %0d, expected 0x10..0x1B", e, issue_q.size()); end
    tests_run++;
    if (first_csb !== 1 || last_csb !== 12) begin
      tests_failed++; $display("FAIL basic_rd_window: got cycles %0d..%0d, expected 1..12", first_csb, last_csb);
    end
    tests_run++;
    if (first_vld !== 3) begin tests_failed++; $display("FAIL basic_first_valid: got cycle %0d, expected 3", first_vld); end
    tests_run++;
    if (out_d.size() !== 12) begin tests_failed++; $display("FAIL basic_count: got %0d words, expected 12", out_d.size()); end
    e = stream_errors(8'h10, 12, 2);
    tests_run++;
    if (e !== 0) begin tests_failed++; $display("FAIL basic_data: %0d mismatches, expected 0", e); end
    tests_run++;
    if (done_cyc !== 15 || done_cyc !== last_hs + 1) begin
      tests_failed++; $display("FAIL basic_done: got cycle %0d (last hs %0d), expected 15", done_cyc, last_hs);
    end
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_release: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    bit to; int e;
    lat = 1;
    run_tile(8'h10, 8'd2, 8'd3, 8'd8, 1, to);
    tests_run++;
    if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: done not seen"); end
    tests_run++;
    if (out_d.size() !== 12) begin tests_failed++; $display("FAIL bp_count: got %0d words, expected 12", out_d.size()); end
    e = stream_errors(8'h10, 12, 2) + issue_errors(8'h10, 12);
    tests_run++;
    if (e !== 0) begin tests_failed++; $display("FAIL bp_data: %0d mismatches, expected 0", e); end
    tests_run++;
    if (stable_err !== 0) begin tests_failed++; $display("FAIL bp_stable: %0d stall cycles changed m_data, expected 0", stable_err); end
    tests_run++;
    if (credit_err !== 0 || max_out !== DEPTH) begin
      tests_failed++; $display("FAIL bp_credit: got %0d overissues, peak outstanding %0d, expected 0 and %0d", credit_err, max_out, DEPTH);
    end
  endtask

  task automatic test_latency3();
    bit to; int e;
    lat = 3;
    run_tile(8'h40, 8'd2, 8'd3, 8'd8, 0, to);
    tests_run++;
    if (to !== 1'b0) begin tests_failed++; $display("FAIL lat3_timeout: done not seen"); end
    tests_run++;
    if (out_d.size() !== 12) begin tests_failed++; $display("FAIL lat3_count: got %0d words, expected 12", out_d.size()); end
    e = stream_errors(8'h40, 12, 2) + issue_errors(8'h40, 12);
    tests_run++;
    if (e !== 0) begin tests_failed++; $display("FAIL lat3_data: %0d mismatches, expected 0", e); end
    tests_run++;
    if (credit_err !== 0 || max_out > DEPTH) begin
      tests_failed++; $display("FAIL lat3_credit: got %0d overissues, peak %0d, expected 0 and <=%0d", credit_err, max_out, DEPTH);
    end
    lat = 1;
  endtask

  task automatic test_zero_ct();
    bit to;
    run_tile(8'h20, 8'd3, 8'd3, 8'd2, 0, to);
    tests_run++;
    if (to !== 1'b0 || done_cyc !== 1) begin
      tests_failed++; $display("FAIL zero_done: got done cycle %0d, expected 1", done_cyc);
    end
    tests_run++;
    if (issue_q.size() !== 0 || any_valid !== 1'b0) begin
      tests_failed++; $display("FAIL zero_idle: got %0d reads valid_seen=%b, expected 0 0", issue_q.size(), any_valid);
    end
  endtask

  task automatic test_addr_wrap();
    bit to; int e;
    run_tile(8'hFE, 8'd1, 8'd1, 8'd16, 0, to);
    e = issue_errors(8'hFE, 4);
    tests_run++;
    if (to !== 1'b0 || e !== 0) begin
      tests_failed++; $display("FAIL wrap_addr: %0d bad reads (timeout=%b), expected FE FF 00 01", e, to);
    end
    e = stream_errors(8'hFE, 4, 4);
    tests_run++;
    if (out_d.size() !== 4 || e !== 0) begin
      tests_failed++; $display("FAIL wrap_data: got %0d words %0d mismatches, expected 4 and 0", out_d.size(), e);
    end
  endtask

  task automatic test_reset_mid_tile();
    bit to; int e;
    lat = 2;
    clear_mon();
    base_addr = 8'h80; b_dim = 8'd2; w_dim = 8'd3; c_dim = 8'd16;
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    for (int n = 0; n < 200 && out_d.size() < 5; n++) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b0;
    #2;
    tests_run++;
    if ({busy, done, rd_csb, rd_addr, m_valid, m_last} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0} || m_data !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got ctrl=%b data=%h, expected 0_0_1_00000000_0_0 and 0",
               {busy, done, rd_csb, rd_addr, m_valid, m_last}, m_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    tests_run++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_discard: got valid=%b busy=%b, expected 0 0", m_valid, busy);
    end
    run_tile(8'h80, 8'd2, 8'd3, 8'd16, 0, to);
    tests_run++;
    if (to !== 1'b0 || out_d.size() !== 24) begin
      tests_failed++; $display("FAIL midrst_count: got %0d words (timeout=%b), expected 24", out_d.size(), to);
    end
    e = stream_errors(8'h80, 24, 4) + issue_errors(8'h80, 24);
    tests_run++;
    if (e !== 0) begin tests_failed++; $display("FAIL midrst_data: %0d mismatches, expected 0", e); end
    lat = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_latency3();
    test_zero_ct();
    test_addr_wrap();
    test_reset_mid_tile();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
